// File: rtl/blink_period_meter.sv
// blink_period_meter
//
// Watches the single-bit output of the blink LED generator and measures the
// length, in clock cycles, of every high and low run. Each completed run is
// compared against EXP_HALF +/- TOL. LOCK_N consecutive good runs assert
// `locked`. A bad run or a stalled input raises the sticky `err` flag, and a
// stalled input also raises the sticky `stuck` flag.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   blink_in   in   blink result, synchronous to clk
//   clear      in   synchronous clear of statistics and FSM (rst wins)
//   half_len   out  length of the last completed run
//   len_valid  out  one-cycle pulse when half_len updates
//   toggle_cnt out  number of measured runs, saturating at 255
//   locked     out  LOCK_N consecutive good runs since last error/clear
//   err        out  sticky: out-of-tolerance run or stall seen
//   stuck      out  sticky: no edge within EXP_HALF+TOL+1 cycles while measuring
module blink_period_meter #(
  parameter int CNT_W    = 19,
  parameter int EXP_HALF = 65536,
  parameter int TOL      = 4,
  parameter int LOCK_N   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  input  logic             clear,
  output logic [CNT_W-1:0] half_len,
  output logic             len_valid,
  output logic [7:0]       toggle_cnt,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  // Limits are held one bit wider than the counter so EXP_HALF+TOL+1 fits.
  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0] LIM_HI   = (CNT_W+1)'(EXP_HALF + TOL);
  localparam logic [CNT_W:0] LIM_LO   = (EXP_HALF > TOL) ? (CNT_W+1)'(EXP_HALF - TOL) : '0;
  localparam logic [CNT_W:0] STALL_AT = (CNT_W+1)'(EXP_HALF + TOL + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_N);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              in_q_reg;
  logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;
  logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
  logic [CNT_W-1:0]  half_len_reg, half_len_next;
  logic              len_valid_reg, len_valid_next;
  logic [7:0]        toggle_cnt_reg, toggle_cnt_next;
  logic              locked_reg, locked_next;
  logic              err_reg, err_next;
  logic              stuck_reg, stuck_next;

  logic              edge_det;
  logic [CNT_W:0]    run_ext;
  logic              run_good;
  logic [GOOD_W-1:0] good_inc;

  always_comb begin
    edge_det = blink_in ^ in_q_reg;
    run_ext  = {1'b0, run_cnt_reg};
    run_good = (run_ext >= LIM_LO) && (run_ext <= LIM_HI);
    good_inc = (good_cnt_reg == GOOD_MAX) ? GOOD_MAX : good_cnt_reg + 1'b1;

    state_next      = state_reg;
    good_cnt_next   = good_cnt_reg;
    half_len_next   = half_len_reg;
    len_valid_next  = 1'b0;
    toggle_cnt_next = toggle_cnt_reg;
    locked_next     = locked_reg;
    err_next        = err_reg;
    stuck_next      = stuck_reg;

    // Counter runs in every state; only MEASURE looks at its value.
    if (edge_det) begin
      run_cnt_next = CNT_W'(1);
    end else if (run_cnt_reg == {CNT_W{1'b1}}) begin
      run_cnt_next = run_cnt_reg;
    end else begin
      run_cnt_next = run_cnt_reg + 1'b1;
    end

    unique case (state_reg)
      SYNC: begin
        // First run after reset/clear is partial: start measuring from here.
        if (edge_det) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          half_len_next  = run_cnt_reg;
          len_valid_next = 1'b1;
          if (toggle_cnt_reg != 8'hFF) begin
            toggle_cnt_next = toggle_cnt_reg + 1'b1;
          end
          if (run_good) begin
            good_cnt_next = good_inc;
            locked_next   = (good_inc == GOOD_MAX);
          end else begin
            err_next      = 1'b1;
            good_cnt_next = '0;
            locked_next   = 1'b0;
          end
        end else if (run_ext >= STALL_AT) begin
          state_next    = STALL;
          err_next      = 1'b1;
          stuck_next    = 1'b1;
          good_cnt_next = '0;
          locked_next   = 1'b0;
        end
      end
      STALL: begin
        // The stalled run is never reported; just restart measuring.
        if (edge_det) begin
          state_next = MEASURE;
        end
      end
      default: begin
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q_reg       <= 1'b0;
      state_reg      <= SYNC;
      run_cnt_reg    <= '0;
      good_cnt_reg   <= '0;
      half_len_reg   <= '0;
      len_valid_reg  <= 1'b0;
      toggle_cnt_reg <= '0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      stuck_reg      <= 1'b0;
    end else if (clear) begin
      // Keep tracking the input so an edge coinciding with clear is swallowed.
      in_q_reg       <= blink_in;
      state_reg      <= SYNC;
      run_cnt_reg    <= '0;
      good_cnt_reg   <= '0;
      half_len_reg   <= '0;
      len_valid_reg  <= 1'b0;
      toggle_cnt_reg <= '0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      stuck_reg      <= 1'b0;
    end else begin
      in_q_reg       <= blink_in;
      state_reg      <= state_next;
      run_cnt_reg    <= run_cnt_next;
      good_cnt_reg   <= good_cnt_next;
      half_len_reg   <= half_len_next;
      len_valid_reg  <= len_valid_next;
      toggle_cnt_reg <= toggle_cnt_next;
      locked_reg     <= locked_next;
      err_reg        <= err_next;
      stuck_reg      <= stuck_next;
    end
  end

  assign half_len   = half_len_reg;
  assign len_valid  = len_valid_reg;
  assign toggle_cnt = toggle_cnt_reg;
  assign locked     = locked_reg;
  assign err        = err_reg;
  assign stuck      = stuck_reg;

endmodule

// File: tb/tb_blink_period_meter.sv
// Testbench for blink_period_meter (CNT_W=8, EXP_HALF=8, TOL=1, LOCK_N=2).
// A timestamp-based reference model predicts every output each cycle; a set
// of hand-computed checks pins the model at key points of each scenario.
module tb_blink_period_meter;

  localparam int CNT_W    = 8;
  localparam int EXP_HALF = 8;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             blink_in = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] half_len;
  logic             len_valid;
  logic [7:0]       toggle_cnt;
  logic             locked;
  logic             err;
  logic             stuck;

  int tests = 0;
  int fails = 0;

  blink_period_meter #(
    .CNT_W(CNT_W), .EXP_HALF(EXP_HALF), .TOL(TOL), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk), .rst(rst), .blink_in(blink_in), .clear(clear),
    .half_len(half_len), .len_valid(len_valid), .toggle_cnt(toggle_cnt),
    .locked(locked), .err(err), .stuck(stuck)
  );

  always #5 clk = ~clk;

  // Reference model: edges are timestamped; a run length is the difference
  // between consecutive edge timestamps. phase 0 = waiting for first edge,
  // 1 = measuring, 2 = stalled.
  int m_cyc = 0;
  int m_last = 0;
  int m_phase = 0;
  int m_good = 0;
  int m_len;
  bit m_prev = 1'b0;
  bit m_valid = 1'b0;
  int exp_half = 0, exp_lv = 0, exp_tc = 0, exp_locked = 0, exp_err = 0, exp_stuck = 0;

  always @(posedge clk) begin
    m_cyc++;
    if (rst || clear) begin
      m_prev     = rst ? 1'b0 : blink_in;
      m_phase    = 0;
      m_good     = 0;
      exp_half   = 0; exp_lv = 0; exp_tc = 0;
      exp_locked = 0; exp_err = 0; exp_stuck = 0;
      if (rst) m_valid = 1'b1;
    end else if (m_valid) begin
      exp_lv = 0;
      if (blink_in != m_prev) begin
        if (m_phase == 1) begin
          m_len    = m_cyc - m_last;
          exp_half = m_len;
          exp_lv   = 1;
          if (exp_tc < 255) exp_tc++;
          if (m_len >= EXP_HALF - TOL && m_len <= EXP_HALF + TOL) begin
            m_good++;
            if (m_good >= LOCK_N) exp_locked = 1;
          end else begin
            exp_err = 1; m_good = 0; exp_locked = 0;
          end
        end
        m_phase = 1;
        m_last  = m_cyc;
      end else if (m_phase == 1 && (m_cyc - m_last) >= EXP_HALF + TOL + 1) begin
        m_phase = 2; exp_err = 1; exp_stuck = 1; m_good = 0; exp_locked = 0;
      end
      m_prev = blink_in;
    end
  end

  // Count len_valid pulses (sampled before each posedge update).
  int lv_total = 0;
  always @(posedge clk) if (len_valid === 1'b1) lv_total++;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_half_len",   int'(half_len),   exp_half);
      chk("m_len_valid",  int'(len_valid),  exp_lv);
      chk("m_toggle_cnt", int'(toggle_cnt), exp_tc);
      chk("m_locked",     int'(locked),     exp_locked);
      chk("m_err",        int'(err),        exp_err);
      chk("m_stuck",      int'(stuck),      exp_stuck);
    end
  end

  // Hold blink_in at `level` for n posedges.
  task automatic hold(input bit level, input int n);
    @(negedge clk);
    blink_in = level;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int snap;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_half_len", int'(half_len), 0);
    chk("rst_toggle_cnt", int'(toggle_cnt), 0);
    chk("rst_flags", int'({len_valid, locked, err, stuck}), 0);

    // Ideal square wave
    hold(1'b0, 5);
    hold(1'b1, 8);
    chk("sq_no_partial", int'(toggle_cnt), 0);
    snap = lv_total;
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    chk("sq_half_len", int'(half_len), 8);
    chk("sq_toggle_cnt", int'(toggle_cnt), 3);
    chk("sq_locked", int'(locked), 1);
    chk("sq_err", int'(err), 0);
    chk("sq_pulses", lv_total - snap, 3);

    // Tolerance boundary: 7 and 9 good, 10 bad
    hold(1'b1, 7);
    hold(1'b0, 9);
    hold(1'b1, 10);
    chk("tol_half_9", int'(half_len), 9);
    chk("tol_locked", int'(locked), 1);
    chk("tol_err0", int'(err), 0);
    hold(1'b0, 8);
    chk("tol_half_10", int'(half_len), 10);
    chk("tol_err1", int'(err), 1);
    chk("tol_unlock", int'(locked), 0);

    // Stuck
    do_reset();
    chk("rst2_err", int'(err), 0);
    hold(1'b0, 3);
    hold(1'b1, 8);
    snap = lv_total;
    @(negedge clk); blink_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("stuck_early", int'(stuck), 0);
    @(negedge clk);
    chk("stuck_set", int'(stuck), 1);
    chk("stuck_err", int'(err), 1);
    repeat (9) @(negedge clk);
    chk("stuck_pulses", lv_total - snap, 1);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    chk("stuck_relock", int'(locked), 1);
    chk("stuck_sticky", int'({err, stuck}), 3);
    chk("stuck_tc", int'(toggle_cnt), 3);

    // Clear mid-run, coinciding with an edge
    hold(1'b0, 4);
    @(negedge clk); blink_in = 1'b1; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_half_len", int'(half_len), 0);
    chk("clr_flags", int'({len_valid, locked, err, stuck}), 0);
    chk("clr_tc", int'(toggle_cnt), 0);
    snap = lv_total;
    hold(1'b1, 5);
    hold(1'b0, 8);
    chk("clr_sync_pulses", lv_total - snap, 0);
    hold(1'b1, 8);
    chk("clr_half_8", int'(half_len), 8);
    chk("clr_tc1", int'(toggle_cnt), 1);

    // Reset mid-run
    hold(1'b0, 3);
    @(negedge clk); blink_in = 1'b1; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rstm_half_len", int'(half_len), 0);
    chk("rstm_flags", int'({len_valid, locked, err, stuck}), 0);
    snap = lv_total;
    hold(1'b1, 5);
    chk("rstm_sync_pulses", lv_total - snap, 0);
    hold(1'b0, 8);
    chk("rstm_half_6", int'(half_len), 6);
    chk("rstm_err", int'(err), 1);

    // Saturation
    do_reset();
    hold(1'b0, 2);
    for (int i = 0; i < 300; i++) hold((i % 2) == 0, 8);
    chk("sat_tc", int'(toggle_cnt), 255);
    chk("sat_locked", int'(locked), 1);
    chk("sat_err", int'(err), 0);

    // Fastest toggle
    do_reset();
    hold(1'b0, 2);
    snap = lv_total;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); blink_in = ~blink_in;
    end
    @(negedge clk);
    chk("fast_lv", int'(len_valid), 1);
    chk("fast_half", int'(half_len), 1);
    chk("fast_err", int'(err), 1);
    chk("fast_tc", int'(toggle_cnt), 19);
    chk("fast_pulses", lv_total - snap, 18);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
